// File: rtl/alu_seq_top.sv
`default_nettype none
// ============================================================================
// Module : alu_seq_top
// Brief  : Valid/ready signed ALU; single-cycle ops plus a WIDTH-cycle
//          restoring divider, status flags, optional saturation/arith shift.
// Rev    : 1.0  initial release
// ============================================================================
module alu_seq_top #(
  parameter int WIDTH       = 16,
  parameter bit SATURATE    = 1'b0,
  parameter bit SHIFT_ARITH = 1'b0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic [3:0]         alu_func,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] result,
  output logic [WIDTH-1:0]   remainder,
  output logic               arith_flag,
  output logic               logic_flag,
  output logic               cmp_flag,
  output logic               shift_flag,
  output logic               carry_out,
  output logic               overflow,
  output logic               div_by_zero,
  output logic               zero
);

  localparam logic [3:0] c_OP_ADD  = 4'b0000;
  localparam logic [3:0] c_OP_SUB  = 4'b0001;
  localparam logic [3:0] c_OP_MUL  = 4'b0010;
  localparam logic [3:0] c_OP_DIV  = 4'b0011;
  localparam logic [3:0] c_OP_AND  = 4'b0100;
  localparam logic [3:0] c_OP_OR   = 4'b0101;
  localparam logic [3:0] c_OP_NAND = 4'b0110;
  localparam logic [3:0] c_OP_NOR  = 4'b0111;
  localparam logic [3:0] c_OP_NOP  = 4'b1000;
  localparam logic [3:0] c_OP_EQ   = 4'b1001;
  localparam logic [3:0] c_OP_GT   = 4'b1010;
  localparam logic [3:0] c_OP_LT   = 4'b1011;
  localparam logic [3:0] c_OP_ASR  = 4'b1100;
  localparam logic [3:0] c_OP_ASL  = 4'b1101;
  localparam logic [3:0] c_OP_BSR  = 4'b1110;
  localparam logic [3:0] c_OP_BSL  = 4'b1111;

  localparam logic [3:0] c_CLS_ARITH = 4'b1000;
  localparam logic [3:0] c_CLS_LOGIC = 4'b0100;
  localparam logic [3:0] c_CLS_CMP   = 4'b0010;
  localparam logic [3:0] c_CLS_SHIFT = 4'b0001;

  localparam int                 c_CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(WIDTH - 1);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_DIV  = 1'b1
  } state_t;

  function automatic logic [2*WIDTH-1:0] f_sext_w(input logic [WIDTH-1:0] x);
    return {{WIDTH{x[WIDTH-1]}}, x};
  endfunction

  function automatic logic [2*WIDTH-1:0] f_sext_w1(input logic [WIDTH:0] x);
    return {{(WIDTH-1){x[WIDTH]}}, x};
  endfunction

  function automatic logic [2*WIDTH-1:0] f_zext_w(input logic [WIDTH-1:0] x);
    return {{WIDTH{1'b0}}, x};
  endfunction

  function automatic logic [2*WIDTH-1:0] f_zext_w1(input logic [WIDTH:0] x);
    return {{(WIDTH-1){1'b0}}, x};
  endfunction

  state_t               r_state;
  logic                 r_out_valid;
  logic [2*WIDTH-1:0]   r_result;
  logic [WIDTH-1:0]     r_remainder;
  logic [3:0]           r_cls;
  logic                 r_carry;
  logic                 r_ovf;
  logic                 r_dbz;
  logic                 r_zero;

  logic [c_CNT_W-1:0]   r_div_cnt;
  logic [WIDTH-1:0]     r_div_rem;
  logic [WIDTH-1:0]     r_div_q;
  logic [WIDTH-1:0]     r_div_d;
  logic                 r_neg_q;
  logic                 r_neg_r;

  logic                 w_accept;
  logic                 w_div_start;
  logic [WIDTH:0]       w_a_ext;
  logic [WIDTH:0]       w_b_ext;
  logic [WIDTH:0]       w_sum;
  logic [WIDTH:0]       w_dif;
  logic [2*WIDTH-1:0]   w_prod;
  logic                 w_prod_fits;
  logic [WIDTH-1:0]     w_shx;
  logic [WIDTH:0]       w_shl;
  logic [WIDTH:0]       w_shr;
  logic [WIDTH-1:0]     w_a_mag;
  logic [WIDTH-1:0]     w_b_mag;

  logic [WIDTH:0]       w_rem_sh;
  logic [WIDTH:0]       w_rem_try;
  logic                 w_q_bit;
  logic [WIDTH-1:0]     w_rem_nx;
  logic [WIDTH-1:0]     w_q_nx;
  logic [WIDTH:0]       w_div_q_s;
  logic [WIDTH-1:0]     w_div_r;

  logic [2*WIDTH-1:0]   w_res;
  logic [WIDTH-1:0]     w_rem;
  logic [3:0]           w_cls;
  logic                 w_carry;
  logic                 w_ovf;
  logic                 w_dbz;

  assign in_ready    = (r_state == S_IDLE) && (!r_out_valid || out_ready);
  assign w_accept    = in_valid && in_ready;
  assign w_div_start = (alu_func == c_OP_DIV) && (|b);

  assign w_a_ext = {a[WIDTH-1], a};
  assign w_b_ext = {b[WIDTH-1], b};
  assign w_sum   = w_a_ext + w_b_ext;
  assign w_dif   = w_a_ext - w_b_ext;

  assign w_prod      = $signed(f_sext_w(a)) * $signed(f_sext_w(b));
  assign w_prod_fits = (&w_prod[2*WIDTH-1:WIDTH-1]) || !(|w_prod[2*WIDTH-1:WIDTH-1]);

  assign w_shx = alu_func[1] ? b : a;
  assign w_shl = {w_shx, 1'b0};
  assign w_shr = SHIFT_ARITH ? {w_shx[WIDTH-1], w_shx[WIDTH-1], w_shx[WIDTH-1:1]}
                             : {2'b00, w_shx[WIDTH-1:1]};

  // Magnitudes are unsigned, so -2^(WIDTH-1) maps cleanly to 2^(WIDTH-1).
  assign w_a_mag = a[WIDTH-1] ? (-a) : a;
  assign w_b_mag = b[WIDTH-1] ? (-b) : b;

  // One restoring step: shift in the next dividend bit, keep the trial
  // difference only when it did not borrow.
  assign w_rem_sh  = {r_div_rem, r_div_q[WIDTH-1]};
  assign w_rem_try = w_rem_sh - {1'b0, r_div_d};
  assign w_q_bit   = !w_rem_try[WIDTH];
  assign w_rem_nx  = w_q_bit ? w_rem_try[WIDTH-1:0] : w_rem_sh[WIDTH-1:0];
  assign w_q_nx    = {r_div_q[WIDTH-2:0], w_q_bit};
  assign w_div_q_s = r_neg_q ? (-{1'b0, w_q_nx}) : {1'b0, w_q_nx};
  assign w_div_r   = r_neg_r ? (-w_rem_nx) : w_rem_nx;

  always_comb begin
    w_res   = '0;
    w_rem   = '0;
    w_cls   = 4'b0000;
    w_carry = 1'b0;
    w_ovf   = 1'b0;
    w_dbz   = 1'b0;
    case (alu_func)
      // Unsigned carry-out recovered from the sign-extended sum and operand signs.
      c_OP_ADD: begin
        w_cls   = c_CLS_ARITH;
        w_carry = w_sum[WIDTH] ^ a[WIDTH-1] ^ b[WIDTH-1];
        w_ovf   = w_sum[WIDTH] ^ w_sum[WIDTH-1];
        if (SATURATE && w_ovf)
          w_res = f_sext_w(w_sum[WIDTH] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}});
        else
          w_res = f_sext_w1(w_sum);
      end
      c_OP_SUB: begin
        w_cls   = c_CLS_ARITH;
        w_carry = w_dif[WIDTH] ^ a[WIDTH-1] ^ ~b[WIDTH-1];
        w_ovf   = w_dif[WIDTH] ^ w_dif[WIDTH-1];
        if (SATURATE && w_ovf)
          w_res = f_sext_w(w_dif[WIDTH] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}});
        else
          w_res = f_sext_w1(w_dif);
      end
      c_OP_MUL: begin
        w_cls = c_CLS_ARITH;
        w_ovf = !w_prod_fits;
        w_res = w_prod;
      end
      c_OP_DIV: begin
        w_cls = c_CLS_ARITH;
        w_dbz = 1'b1;
        w_rem = a;
      end
      c_OP_AND: begin
        w_cls = c_CLS_LOGIC;
        w_res = f_zext_w(a & b);
      end
      c_OP_OR: begin
        w_cls = c_CLS_LOGIC;
        w_res = f_zext_w(a | b);
      end
      c_OP_NAND: begin
        w_cls = c_CLS_LOGIC;
        w_res = f_zext_w(~(a & b));
      end
      c_OP_NOR: begin
        w_cls = c_CLS_LOGIC;
        w_res = f_zext_w(~(a | b));
      end
      c_OP_NOP: w_cls = c_CLS_CMP;
      c_OP_EQ: begin
        w_cls = c_CLS_CMP;
        w_res = {{(2*WIDTH-2){1'b0}}, (a == b) ? 2'd1 : 2'd0};
      end
      c_OP_GT: begin
        w_cls = c_CLS_CMP;
        w_res = {{(2*WIDTH-2){1'b0}}, ($signed(a) > $signed(b)) ? 2'd2 : 2'd0};
      end
      c_OP_LT: begin
        w_cls = c_CLS_CMP;
        w_res = {{(2*WIDTH-2){1'b0}}, ($signed(a) < $signed(b)) ? 2'd3 : 2'd0};
      end
      c_OP_ASR, c_OP_ASL, c_OP_BSR, c_OP_BSL: begin
        w_cls = c_CLS_SHIFT;
        w_res = f_zext_w1(alu_func[0] ? w_shl : w_shr);
      end
      default: w_cls = 4'b0000;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_out_valid <= 1'b0;
      r_result    <= '0;
      r_remainder <= '0;
      r_cls       <= '0;
      r_carry     <= 1'b0;
      r_ovf       <= 1'b0;
      r_dbz       <= 1'b0;
      r_zero      <= 1'b0;
      r_div_cnt   <= '0;
      r_div_rem   <= '0;
      r_div_q     <= '0;
      r_div_d     <= '0;
      r_neg_q     <= 1'b0;
      r_neg_r     <= 1'b0;
    end else begin
      if (r_out_valid && out_ready)
        r_out_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            if (w_div_start) begin
              r_state   <= S_DIV;
              r_div_cnt <= '0;
              r_div_rem <= '0;
              r_div_q   <= w_a_mag;
              r_div_d   <= w_b_mag;
              r_neg_q   <= a[WIDTH-1] ^ b[WIDTH-1];
              r_neg_r   <= a[WIDTH-1];
            end else begin
              r_out_valid <= 1'b1;
              r_result    <= w_res;
              r_remainder <= w_rem;
              r_cls       <= w_cls;
              r_carry     <= w_carry;
              r_ovf       <= w_ovf;
              r_dbz       <= w_dbz;
              r_zero      <= (w_res == '0);
            end
          end
        end
        S_DIV: begin
          r_div_rem <= w_rem_nx;
          r_div_q   <= w_q_nx;
          r_div_cnt <= r_div_cnt + c_CNT_W'(1);
          // Last quotient bit is folded straight into the output registers.
          if (r_div_cnt == c_CNT_LAST) begin
            r_state     <= S_IDLE;
            r_div_cnt   <= '0;
            r_out_valid <= 1'b1;
            r_result    <= f_sext_w1(w_div_q_s);
            r_remainder <= w_div_r;
            r_cls       <= c_CLS_ARITH;
            r_carry     <= 1'b0;
            r_ovf       <= w_div_q_s[WIDTH] ^ w_div_q_s[WIDTH-1];
            r_dbz       <= 1'b0;
            r_zero      <= (w_div_q_s == '0);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign out_valid   = r_out_valid;
  assign result      = r_result;
  assign remainder   = r_remainder;
  assign arith_flag  = r_cls[3];
  assign logic_flag  = r_cls[2];
  assign cmp_flag    = r_cls[1];
  assign shift_flag  = r_cls[0];
  assign carry_out   = r_carry;
  assign overflow    = r_ovf;
  assign div_by_zero = r_dbz;
  assign zero        = r_zero;

endmodule
`default_nettype wire

// File: doc/alu_seq_top.md
Name: alu_seq_top

Overview:
Parametrised successor to the single-cycle signed ALU. It keeps the 16-entry alu_func encoding but adds a valid/ready handshake on input and output. Signed division runs on a multi-cycle restoring divider instead of a combinational one. It also adds signed-overflow, divide-by-zero and zero flags, optional add/sub saturation, and optional arithmetic right shift. It sits between the instruction decoder and the writeback register.

Parameters:
WIDTH, 16, operand width in bits (≥4)
SATURATE, 0, 1 = clamp add/sub result to the WIDTH-bit signed range on overflow
SHIFT_ARITH, 0, 1 = right shifts are arithmetic (sign-fill); 0 = logical

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
in_valid  in  1  operand/func valid
in_ready  out  1  block can accept
a  in  WIDTH  signed operand A
b  in  WIDTH  signed operand B
alu_func  in  4  operation code
out_valid  out  1  result valid
out_ready  in  1  downstream accepts result
result  out  2*WIDTH  signed result
remainder  out  WIDTH  signed remainder (div only, else 0)
arith_flag, logic_flag, cmp_flag, shift_flag  out  1 each  one-hot operation class of result
carry_out  out  1  add/sub carry
overflow  out  1  signed result does not fit WIDTH bits
div_by_zero  out  1  div with b==0
zero  out  1  result==0

Behaviour:
- Reset (rst=0, async): state IDLE; out_valid=0, all result/flag outputs 0, divider counter 0. in_ready reads 1 once reset is released.
- States: IDLE, DIV.
- in_ready = (state==IDLE) && (!out_valid || out_ready), combinational.
- Accept = in_valid && in_ready. a, b and alu_func are sampled only at accept; later changes are ignored.
- Non-div ops: result registered on the accept edge; out_valid=1 after that edge. Back-to-back throughput is 1 per cycle while out_ready=1.
- Div (0011), b!=0: go to DIV for exactly WIDTH cycles, one quotient bit per cycle on magnitudes.
  - Result and out_valid are registered at the WIDTH-th edge after accept; state then returns to IDLE.
  - Quotient truncates toward zero; remainder takes the dividend's sign.
  - Quotient is sign-extended to 2*WIDTH.
  - -2^(WIDTH-1)/-1 gives +2^(WIDTH-1) with overflow=1.
- Div, b==0: no DIV state; 1-cycle latency; result=0, remainder=a, div_by_zero=1, arith_flag=1.
- Output hold: while out_valid && !out_ready, all outputs are frozen. out_valid clears on out_ready unless a new result is registered on the same edge.
- Func map:
  - 0000 add, 0001 sub: result = exact WIDTH+1-bit sum/difference, sign-extended.
    - carry_out = bit WIDTH of the unsigned a+b or a+~b+1.
    - overflow = WIDTH-bit signed overflow.
    - When SATURATE=1 and overflow=1, result is clamped to 2^(WIDTH-1)-1 or -2^(WIDTH-1); overflow still reads 1.
  - 0010 mul: full 2*WIDTH signed product, 1 cycle; overflow=1 if the product does not fit WIDTH bits.
  - 0100 AND, 0101 OR, 0110 NAND, 0111 NOR: WIDTH-bit result, zero-extended; logic_flag=1.
  - 1000 NOP: result=0, cmp_flag=1.
  - 1001 EQ, 1010 GT, 1011 LT (signed compares): result = 1, 2 or 3 respectively when true, 0 when false; cmp_flag=1.
  - 1100 A>>1, 1101 A<<1, 1110 B>>1, 1111 B<<1: result[WIDTH:0] only, upper bits 0; shift_flag=1.
    - Left shift = {x,1'b0}.
    - Right shift = {1'b0, x>>1} when SHIFT_ARITH=0, or sign-filled x>>>1 sign-extended to WIDTH+1 when SHIFT_ARITH=1.
- Flag defaults: carry_out, overflow and div_by_zero are 0 for every op not listed above. zero is evaluated on the final result for all ops.
- Reset mid-DIV aborts the division immediately; no out_valid pulse follows.

Test Plan:
1. add -100,-30 accepted with out_ready=1 → one edge later out_valid=1, result=-130, flags {arith,logic,cmp,shift}=1000, overflow=0; sub 100,30 back-to-back → result=70 the next cycle.
2. add 32767+1, WIDTH=16: SATURATE=0 instance → result=32768, overflow=1; SATURATE=1 instance → result=32767, overflow=1; sub 0-1 → carry_out=0, result=-1.
3. div -100/30 → in_ready=0 for 16 cycles, out_valid rises exactly 16 edges after accept, result=-3, remainder=-10; div 5/0 → 1-cycle latency, div_by_zero=1, result=0, remainder=5.
4. out_ready held 0 after mul 100*-30 → result=-3000 stays frozen and in_ready=0 for 5 cycles; raise out_ready with in_valid high → next result lands on the same edge, no gap.
5. rst pulsed low on cycle 7 of a division → out_valid=0 and outputs 0 immediately; no later out_valid; a new add is accepted after release.
6. GT 100,30 → result=2, cmp_flag=1; EQ 100,30 → result=0, zero=1; B>>1 with b=-30: SHIFT_ARITH=1 → result[16:0]=-15 (17-bit); SHIFT_ARITH=0 → result=0x7FF1.
